ram_bist_ctrl: RTL

RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

---
 rtl/ram_bist_if.sv | 23 ++
 rtl/ram_bist_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ram_bist_if.sv
// RAM-side bus of the BIST controller: one write port and one read port.
// The controller drives the master modport, the RAM model the slave modport.
interface ram_bist_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    output ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
    input  ram_rdata
  );

  modport slave (
    input  ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
    output ram_rdata
  );
endinterface

// File: rtl/ram_bist_ctrl.sv
// Two-phase RAM BIST: writes address-derived patterns, reads them back, and compares
// each read against its own expected value after the RAM read latency.
module ram_bist_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  ram_bist_if.master            ram,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);
  localparam int                    LAT        = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam logic                  DRAIN_LAST = 1'(LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic                  ph_r, ph_s;
  logic                  drain_cnt_r, drain_cnt_s;

  logic                  we_r, re_r;
  logic [ADDR_WIDTH-1:0] waddr_r, raddr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic [1:0]            vld_r;
  logic [DATA_WIDTH-1:0] exp_r [2];
  logic [ADDR_WIDTH-1:0] adr_r [2];
  logic                  mismatch_s;

  function automatic logic [DATA_WIDTH-1:0] expected(input logic [ADDR_WIDTH-1:0] a, input logic p);
    return DATA_WIDTH'(a) ^ {DATA_WIDTH{p}};
  endfunction

  // State, address and phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addr_r      <= '0;
      ph_r        <= 1'b0;
      drain_cnt_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      ph_r        <= ph_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // Next-state sequencing through write, read and drain of both phases
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    ph_s        = ph_r;
    drain_cnt_s = drain_cnt_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WRITE;
          addr_s  = '0;
          ph_s    = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE, READ: begin
        addr_s = addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        if (addr_r == LAST_ADDR) begin
          state_s     = (state_r == WRITE) ? READ : DRAIN;
          drain_cnt_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          drain_cnt_s = 1'b0;
          if (!ph_r) begin
            state_s = WRITE;
            ph_s    = 1'b1;
          end else begin
            state_s = FINISH;
          end
        end else begin
          drain_cnt_s = drain_cnt_r + 1'b1;
        end
      end
      FINISH:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // RAM port and status outputs, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_r    <= 1'b0;
      re_r    <= 1'b0;
      waddr_r <= '0;
      raddr_r <= '0;
      wdata_r <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      we_r    <= (state_s == WRITE);
      re_r    <= (state_s == READ);
      waddr_r <= (state_s == WRITE) ? addr_s : '0;
      raddr_r <= (state_s == READ) ? addr_s : '0;
      wdata_r <= (state_s == WRITE) ? expected(addr_s, ph_s) : '0;
      busy    <= (state_s != IDLE);
      done    <= (state_s == FINISH);
    end
  end

  assign ram.ram_we    = we_r;
  assign ram.ram_re    = re_r;
  assign ram.ram_waddr = waddr_r;
  assign ram.ram_raddr = raddr_r;
  assign ram.ram_wdata = wdata_r;

  // Expected data travels alongside the RAM read pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 2'b00;
      exp_r <= '{default: '0};
      adr_r <= '{default: '0};
    end else begin
      vld_r    <= {vld_r[0], re_r};
      exp_r[0] <= expected(raddr_r, ph_r);
      exp_r[1] <= exp_r[0];
      adr_r[0] <= raddr_r;
      adr_r[1] <= adr_r[0];
    end
  end

  assign mismatch_s = vld_r[LAT-1] && (ram.ram_rdata != exp_r[LAT-1]);

  // Error statistics; pass is latched as the FSM leaves FINISH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 16'd0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else if (state_r == IDLE && start) begin
      err_count <= 16'd0;
      fail_addr <= '0;
      pass      <= 1'b0;
    end else begin
      if (mismatch_s) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    fail_addr <= adr_r[LAT-1];
      end
      if (state_r == FINISH) pass <= (err_count == 16'd0);
    end
  end
endmodule
